count_wrap_monitor: RTL and testbench

- Downstream consumer of the 4-bit free-running `counter` output.
- Samples the count stream and detects each wrap-around (max -> 0).
- Counts wraps and raises a sticky trigger once a programmed number of wraps is reached, modelling a ticking-timebomb trigger.
- Flags any non-sequential step in the observed count, so benches can tell a clean counter from a corrupted one.

---
 rtl/count_wrap_monitor.sv | 125 ++++++++++++
 tb/tb_count_wrap_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/count_wrap_monitor.sv
// Watches a free-running count stream, counts max->0 wraps, fires a sticky
// trigger at a programmed wrap count and flags any illegal count step.
module count_wrap_monitor #(
  parameter int CNT_WIDTH   = 4,
  parameter int WRAP_TARGET = 4,
  parameter int WC_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] count_in,
  input  logic                 count_valid,
  input  logic                 clear,
  output logic                 wrap_pulse,
  output logic [WC_WIDTH-1:0]  wrap_count,
  output logic                 trigger,
  output logic                 step_err,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FIRED = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WC_WIDTH-1:0]  WC_MAX    = '1;
  localparam logic [WC_WIDTH-1:0]  WC_TARGET = WRAP_TARGET[WC_WIDTH-1:0];

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_prev;
  logic                 r_wrap_pulse;
  logic [WC_WIDTH-1:0]  r_wrap_count;
  logic                 r_trigger;
  logic                 r_step_err;

  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] w_prev_next;
  logic                 w_wrap_pulse_next;
  logic [WC_WIDTH-1:0]  w_wrap_count_next;
  logic                 w_trigger_next;
  logic                 w_step_err_next;

  logic [CNT_WIDTH-1:0] w_prev_inc;
  logic [WC_WIDTH-1:0]  w_wc_inc;
  logic                 w_tracking;
  logic                 w_is_stall;
  logic                 w_is_step;
  logic                 w_is_wrap;
  logic                 w_hit;

  // Sample classification against the previous accepted value.
  assign w_prev_inc = r_prev + 1'b1;
  assign w_wc_inc   = (r_wrap_count == WC_MAX) ? r_wrap_count : r_wrap_count + 1'b1;
  assign w_tracking = (r_state == TRACK) || (r_state == FIRED);
  assign w_is_stall = (count_in == r_prev);
  assign w_is_step  = (r_prev != CNT_MAX) && (count_in == w_prev_inc);
  assign w_is_wrap  = (r_prev == CNT_MAX) && (count_in == '0);
  assign w_hit      = w_is_wrap && (w_wc_inc == WC_TARGET);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_wrap_pulse <= 1'b0;
      r_wrap_count <= '0;
      r_trigger    <= 1'b0;
      r_step_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prev       <= w_prev_next;
      r_wrap_pulse <= w_wrap_pulse_next;
      r_wrap_count <= w_wrap_count_next;
      r_trigger    <= w_trigger_next;
      r_step_err   <= w_step_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else if (count_valid) begin
      case (r_state)
        IDLE:    w_state_next = TRACK;
        TRACK:   if (w_hit) w_state_next = FIRED;
        FIRED:   w_state_next = FIRED;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_prev_next       = r_prev;
    w_wrap_pulse_next = 1'b0;
    w_wrap_count_next = r_wrap_count;
    w_trigger_next    = r_trigger;
    w_step_err_next   = r_step_err;
    if (clear) begin
      w_prev_next       = '0;
      w_wrap_count_next = '0;
      w_trigger_next    = 1'b0;
      w_step_err_next   = 1'b0;
    end else if (count_valid) begin
      w_prev_next = count_in;
      // The first sample after IDLE is only a capture, never judged.
      if (w_tracking) begin
        if (w_is_wrap) begin
          w_wrap_pulse_next = 1'b1;
          w_wrap_count_next = w_wc_inc;
          if (w_hit) w_trigger_next = 1'b1;
        end else if (!w_is_stall && !w_is_step) begin
          w_step_err_next = 1'b1;
        end
      end
    end
  end

  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_count;
  assign trigger    = r_trigger;
  assign step_err   = r_step_err;
  assign state      = r_state;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed plus randomized stimulus for two monitor configurations sharing one
// input stream, each compared every cycle against a behavioural wrap model.
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic       count_valid;
  logic       clear;

  logic       wrap_pulse0, trigger0, step_err0;
  logic [7:0] wrap_count0;
  logic [1:0] state0;
  logic       wrap_pulse1, trigger1, step_err1;
  logic [1:0] wrap_count1;
  logic [1:0] state1;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-configuration model: target wrap count and wrap counter ceiling.
  localparam int TGT[2]  = '{4, 1};
  localparam int WMAX[2] = '{255, 3};

  bit m_have[2];
  int m_prev[2];
  int m_wraps[2];
  bit m_pulse[2];
  bit m_err[2];

  int cnt;

  always #5 clk = ~clk;

  count_wrap_monitor #(.CNT_WIDTH(4), .WRAP_TARGET(4), .WC_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
    .clear(clear), .wrap_pulse(wrap_pulse0), .wrap_count(wrap_count0),
    .trigger(trigger0), .step_err(step_err0), .state(state0)
  );

  count_wrap_monitor #(.CNT_WIDTH(4), .WRAP_TARGET(1), .WC_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
    .clear(clear), .wrap_pulse(wrap_pulse1), .wrap_count(wrap_count1),
    .trigger(trigger1), .step_err(step_err1), .state(state1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input int k, input bit v, input int c, input bit clr, input bit rs);
    if (rs || clr) begin
      m_have[k] = 0; m_prev[k] = 0; m_wraps[k] = 0; m_pulse[k] = 0; m_err[k] = 0;
    end else if (v) begin
      m_pulse[k] = 0;
      if (m_have[k]) begin
        if (c == m_prev[k]) begin
        end else if (m_prev[k] < 15 && c == m_prev[k] + 1) begin
        end else if (m_prev[k] == 15 && c == 0) begin
          m_pulse[k] = 1;
          m_wraps[k]++;
        end else begin
          m_err[k] = 1;
        end
      end
      m_have[k] = 1;
      m_prev[k] = c;
    end else begin
      m_pulse[k] = 0;
    end
  endtask

  function automatic int exp_state(input int k);
    if (!m_have[k]) return 0;
    return (m_wraps[k] >= TGT[k]) ? 2 : 1;
  endfunction

  function automatic int exp_wc(input int k);
    return (m_wraps[k] > WMAX[k]) ? WMAX[k] : m_wraps[k];
  endfunction

  task automatic compare_all();
    chk("d0_pulse", 32'(wrap_pulse0), 32'(m_pulse[0]));
    chk("d0_wcount", 32'(wrap_count0), 32'(exp_wc(0)));
    chk("d0_trigger", 32'(trigger0), 32'(m_wraps[0] >= TGT[0]));
    chk("d0_steperr", 32'(step_err0), 32'(m_err[0]));
    chk("d0_state", 32'(state0), 32'(exp_state(0)));
    chk("d1_pulse", 32'(wrap_pulse1), 32'(m_pulse[1]));
    chk("d1_wcount", 32'(wrap_count1), 32'(exp_wc(1)));
    chk("d1_trigger", 32'(trigger1), 32'(m_wraps[1] >= TGT[1]));
    chk("d1_steperr", 32'(step_err1), 32'(m_err[1]));
    chk("d1_state", 32'(state1), 32'(exp_state(1)));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic apply(input bit v, input int c, input bit clr, input bit rs);
    count_valid = v;
    count_in    = 4'(c);
    clear       = clr;
    rst         = rs;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, v, c, clr, rs);
    #1;
    compare_all();
  endtask

  task automatic sample(input int c);
    apply(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    apply(1'b0, int'($urandom_range(0, 15)), 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; count_valid = 1'b0; count_in = '0;
    apply(1'b0, 0, 1'b0, 1'b1);
    apply(1'b1, 5, 1'b0, 1'b1);
    $display("reset: state0=%0d wrap_count0=%0d", state0, wrap_count0);

    // Free-running counter: capture + 80 samples = 5 wraps.
    for (int i = 0; i <= 80; i++) sample(i % 16);
    sample(1);
    sample(2);
    $display("free-run: wrap_count0=%0d trigger0=%0d wrap_count1=%0d trigger1=%0d",
             wrap_count0, trigger0, wrap_count1, trigger1);

    // Clear coincident with a valid 15, then 0 is a capture only.
    apply(1'b1, 15, 1'b1, 1'b0);
    sample(0);
    $display("clear+capture: state0=%0d wrap_pulse0=%0d", state0, wrap_pulse0);

    // Valid toggling every cycle across 14,15,0 and repeated 7,7,8.
    for (int i = 1; i <= 23; i++) begin
      sample(i % 16);
      idle_cycle();
    end
    sample(7);
    idle_cycle();
    sample(7);
    idle_cycle();
    sample(8);
    idle_cycle();
    $display("toggle: wrap_count0=%0d step_err0=%0d", wrap_count0, step_err0);

    // Illegal 3 -> 9, then a clean wrap is still counted.
    apply(1'b0, 0, 1'b1, 1'b0);
    sample(2);
    sample(3);
    sample(9);
    for (int i = 10; i <= 16; i++) sample(i % 16);
    sample(1);
    $display("inject: step_err0=%0d wrap_count0=%0d", step_err0, wrap_count0);

    // Reach FIRED on dut0, reset for one cycle, then recapture.
    for (int i = 2; i <= 66; i++) sample(i % 16);
    apply(1'b1, 3, 1'b0, 1'b1);
    sample(9);
    sample(10);
    $display("reset-in-fired: state0=%0d wrap_count0=%0d", state0, wrap_count0);

    // Randomized mostly-incrementing stream with sparse faults and clears.
    cnt = 10;
    for (int n = 0; n < 3000; n++) begin
      int  r;
      int  c;
      bit  v;
      bit  clr;
      bit  rs;
      v = ($urandom_range(0, 99) < 70);
      r = int'($urandom_range(0, 99));
      if (r < 85)      c = (cnt + 1) % 16;
      else if (r < 95) c = cnt;
      else             c = int'($urandom_range(0, 15));
      clr = ($urandom_range(0, 249) == 0);
      rs  = ($urandom_range(0, 399) == 0);
      if (v) cnt = c;
      apply(v, c, clr, rs);
    end
    $display("random: wrap_count0=%0d wrap_count1=%0d", wrap_count0, wrap_count1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
